// File: rtl/lf_add_pkg.sv
// Shared types, default sizes and the round-robin winner function for the
// shared Ladner-Fischer adder arbiter.
package lf_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_W    = 8;
    localparam int DEFAULT_NREQ = 4;
    // Widest request vector the winner function handles.
    localparam int MAX_NREQ     = 8;

    // One-hot winner among req, searching upward from ptr and wrapping at nreq.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          ptr,
        input int                  nreq
    );
        logic [MAX_NREQ-1:0] win;
        logic                found;
        logic [2:0]          idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if (!found && (k < nreq) && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lf_add_arbiter_core.sv
// W-bit combinational Ladner-Fischer adder with carry-in and carry-out.
// The carry-in is folded into bit 0's generate so the prefix tree delivers
// the true carry out of every bit position.
module lf_adder_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int LV = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] g;
    logic [W-1:0] p;

    genvar gi, li;

    for (gi = 0; gi < W; gi++) begin : bit_gp
        assign g[gi] = a[gi] & b[gi];
        assign p[gi] = a[gi] ^ b[gi];
    end

    // Prefix levels: at level li every bit whose (li-1)-th index bit is set
    // merges with the top bit of the lower half of its block.
    for (li = 0; li <= LV; li++) begin : lvl
        logic [W-1:0] gs;
        logic [W-1:0] ps;
        if (li == 0) begin : base
            assign gs = {g[W-1:1], g[0] | (p[0] & cin)};
            assign ps = p;
        end else begin : merge
            for (gi = 0; gi < W; gi++) begin : node
                if (((gi >> (li - 1)) & 1) == 1) begin : op
                    localparam int J = ((gi >> (li - 1)) << (li - 1)) - 1;
                    assign gs[gi] = lvl[li-1].gs[gi] | (lvl[li-1].ps[gi] & lvl[li-1].gs[J]);
                    assign ps[gi] = lvl[li-1].ps[gi] & lvl[li-1].ps[J];
                end else begin : pass
                    assign gs[gi] = lvl[li-1].gs[gi];
                    assign ps[gi] = lvl[li-1].ps[gi];
                end
            end
        end
    end

    logic [W-1:0] carry_in_vec;
    if (W > 1) begin : cv_wide
        assign carry_in_vec = {lvl[LV].gs[W-2:0], cin};
    end else begin : cv_one
        assign carry_in_vec = cin;
    end

    assign sum  = p ^ carry_in_vec;
    assign cout = lvl[LV].gs[W-1];

    // Final-level group propagates have no consumer.
    logic unused_ps;
    assign unused_ps = ^lvl[LV].ps;

endmodule

// File: rtl/lf_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one Ladner-Fischer adder core among
// NREQ requesters. Optional word chaining is enabled by defining
// LF_ARB_CHAIN_EN: a requester whose word is not last keeps the grant and its
// next word takes the previous carry-out as carry-in.
module lf_add_arbiter
    import lf_add_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = DEFAULT_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum,
    output logic              busy
);

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] id_reg;
    logic [IDW-1:0] rsp_id_reg;
    logic [W-1:0]   a_reg, b_reg;
    logic           cin_reg;
    logic [W:0]     sum_reg;
    logic [W:0]     core_sum;

    logic [W-1:0]   op_a [NREQ];
    logic [W-1:0]   op_b [NREQ];

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : unpack
        assign op_a[gi] = req_a[gi*W +: W];
        assign op_b[gi] = req_b[gi*W +: W];
    end

    logic                locked;
`ifdef LF_ARB_CHAIN_EN
    logic                lock_reg;
    assign locked = lock_reg;
`else
    assign locked = 1'b0;
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    logic [IDW-1:0]      id_inc;
    logic [IDW-1:0]      ptr_eff;
    logic [NREQ-1:0]     req_mask;
    logic [MAX_NREQ-1:0] win_full;
    logic                grant_ok;
    logic [NREQ-1:0]     grant;
    logic                fire;
    logic [IDW-1:0]      gid;
    logic                sel_cin;

    assign id_inc = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;

    // Arbitration: pick the round-robin winner; while a response is being
    // accepted the search already starts just past the responding requester.
    always_comb begin
        req_mask = req_valid;
        if (locked) begin
            req_mask = req_valid & ({{(NREQ-1){1'b0}}, 1'b1} << id_reg);
        end
        ptr_eff = ptr_reg;
        if (state_reg == RESP && !locked) begin
            ptr_eff = id_inc;
        end
        win_full = rr_pick(MAX_NREQ'(req_mask), 3'(ptr_eff), NREQ);
        grant_ok = rst_n && ((state_reg == IDLE) || (state_reg == RESP && rsp_ready));
        grant    = grant_ok ? win_full[NREQ-1:0] : '0;
        fire     = |grant;
        gid      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gid = IDW'(i);
            end
        end
        sel_cin = locked ? sum_reg[W] : req_cin[gid];
    end

    logic unused_win;
    assign unused_win = ^win_full;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (fire) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = fire ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, operand capture, result and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            id_reg     <= '0;
            rsp_id_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cin_reg    <= 1'b0;
            sum_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (fire) begin
                a_reg   <= op_a[gid];
                b_reg   <= op_b[gid];
                cin_reg <= sel_cin;
                id_reg  <= gid;
            end
            if (state_reg == EXEC) begin
                sum_reg    <= core_sum;
                rsp_id_reg <= id_reg;
            end
            if (state_reg == RESP && rsp_ready && !locked) begin
                ptr_reg <= id_inc;
            end
        end
    end

`ifdef LF_ARB_CHAIN_EN
    // Chain lock follows the last flag of each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_reg <= 1'b0;
        end else if (fire) begin
            lock_reg <= !req_last[gid];
        end
    end
`endif

    lf_adder_core #(.W(W)) u_core (
        .a    (a_reg),
        .b    (b_reg),
        .cin  (cin_reg),
        .sum  (core_sum[W-1:0]),
        .cout (core_sum[W])
    );

    assign req_ready = grant;
    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);
    assign rsp_sum   = sum_reg;
    assign rsp_id    = rsp_id_reg;

endmodule

// File: doc/lf_add_arbiter.md
# lf_add_arbiter

Round-robin arbiter and sequencer that shares one 8-bit Ladner-Fischer adder core among several requesters. Each requester presents two operands and a carry-in with a valid/ready handshake. The block grants one requester, registers its operands, and drives them through the combinational adder core. It then returns a registered sum with carry-out and requester ID on a single valid/ready response channel. It sits between the requesting units and the adder datapath and is the only block that drives the adder inputs.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `W`, 8: operand width, matching the adder core
- `IDW`, 2: width of the requester ID, equal to `$clog2(NREQ)`

- `clk`  in  1  sole clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_a`  in  NREQ*W  operand A, packed; requester i occupies `[i*W +: W]`
- `req_b`  in  NREQ*W  operand B, packed the same way
- `req_cin`  in  NREQ  per-requester carry-in
- `req_last`  in  NREQ  last word of a chain (used only with `LF_ARB_CHAIN_EN`)
- `req_ready`  out  NREQ  one-hot grant/accept
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  requester index of the response
- `rsp_sum`  out  W+1  `{cout, sum}`
- `busy`  out  1  high in any state except IDLE

## Operation
- Reset values: every output is 0; state = IDLE; rotation pointer = 0; operand, ID, sum and chain registers = 0.
- States:
  - **IDLE**: `req_ready` is the one-hot round-robin winner among `req_valid`. The search starts at the pointer and wraps modulo NREQ. On a handshake, capture `a`, `b`, `cin`, and `id`, then go to EXEC.
  - **EXEC**: the adder sees the captured operands. Its result is registered into `rsp_sum`/`rsp_id`, and the state moves to RESP.
  - **RESP**: `rsp_valid` = 1. On `rsp_ready`, advance the pointer to `id+1` (mod NREQ). Then grant again in the same cycle if any `req_valid` is high (go to EXEC), otherwise go to IDLE.
- `req_ready` is asserted only in IDLE, or in RESP while `rsp_ready` is high, and only to the winner. `req_ready` is never multi-hot.
- `rsp_sum`/`rsp_id` stay stable while `rsp_valid` && !`rsp_ready`.
- Requester inputs may change freely when not handshaking. Only captured values are used.
- Arithmetic: `rsp_sum` = `a + b + cin`, computed at W+1 bits with no truncation.
- No requests pending: stay in IDLE; the pointer does not move.

## Timing
- Handshake at edge t → EXEC during cycle t..t+1 → `rsp_valid` high after edge t+1. Latency is 2 edges, request to response.
- With `rsp_ready` held high and continuous requests, throughput is one operation per 2 cycles (RESP → EXEC back-to-back).
- With backpressure, RESP holds indefinitely and no new grant is issued.
- Reset asserted mid-operation: the in-flight operation is discarded and all outputs return to their reset values immediately (asynchronous). No response is emitted after reset deassertion.

## Configuration
- `LF_ARB_CHAIN_EN` defined:
  - A grant accepted with `req_last`=0 locks the arbiter to that requester. The pointer does not advance.
  - The next grant, in RESP on `rsp_ready`, goes only to the locked requester. Other requesters are ignored.
  - The locked requester's next word uses the registered carry-out of the previous word as carry-in, and `req_cin` is ignored.
  - The lock releases after the response of the word accepted with `req_last`=1, after which the pointer advances normally.
  - The first word of a chain uses `req_cin`.
- Not defined: `req_last` and chain logic are absent. Every operation uses `req_cin`, and the pointer advances after every response.

## Structure
- Package `lf_add_pkg` holds:
  - the state enum (IDLE, EXEC, RESP);
  - default `W`/`NREQ` constants;
  - a function computing the round-robin one-hot winner from the request vector and pointer.
- One sub-module, `lf_adder_core` (W-bit combinational Ladner-Fischer adder with cin and cout), instantiated once.
- The FSM, arbitration, and registers live in `lf_add_arbiter`.

## Test plan
- **Single request:** reset, then requester 2 issues `a`=8'hFF, `b`=8'h01, `cin`=0 → `rsp_sum`=9'h100, `rsp_id`=2, `rsp_valid` two edges after accept.
- **Round-robin order:** all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0, one response every 2 cycles.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with a response pending → `rsp_sum`/`rsp_id` stable, `req_ready`=0 throughout. Release → the next grant goes to the next index after the current ID.
- **Reset mid-operation:** `rst_n` low during EXEC → `rsp_valid`, `req_ready`, `busy` go to 0 at once. After release, no stale response appears.
- **Chaining (`LF_ARB_CHAIN_EN`):**
  - requester 1 sends words (8'hFF+8'h01, last=0) then (8'h00+8'h00, last=1) while requester 0 is also valid;
  - expected responses, in order: 9'h100 id 1, then 9'h001 id 1;
  - requester 0 is granted only after the chain ends.
- **Carry-in extremes:** `a`=8'hFF, `b`=8'hFF, `cin`=1 → `rsp_sum`=9'h1FF. All-zero operands with `cin`=1 → 9'h001.
